// File: rtl/servant_uart_tx.sv
// servant_uart_tx: Wishbone-attached transmit-only UART.
// A small byte FIFO feeds a START/DATA/STOP shifter whose bit time is
// set by a runtime-programmable baud divisor (clocks per bit).
module servant_uart_tx #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [15:0] DIV_INIT = 16'd868
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_tx,
    output logic        o_irq
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // FIFO storage and circular pointers (one extra wrap bit)
    logic [7:0]  fifo_mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;

    // Shifter datapath
    logic [15:0] divisor;
    logic [15:0] div_m1;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;
    logic        bit_done;
    logic        busy;

    // Bus decode
    logic        ovf;
    logic        bus_acc;
    logic        wr_data;
    logic        wr_div;
    logic        rd_status;
    logic [31:0] status_word;
    logic        unused_dat_hi;

    assign unused_dat_hi = ^i_wb_dat[31:16];

    // A bus access happens only on the cycle that raises ack, so a held
    // cyc produces one access every other cycle.
    assign bus_acc   = i_wb_cyc & ~o_wb_ack;
    assign wr_data   = bus_acc &  i_wb_we & ~i_wb_adr;
    assign wr_div    = bus_acc &  i_wb_we &  i_wb_adr;
    assign rd_status = bus_acc & ~i_wb_we & ~i_wb_adr;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Full/empty are taken before this cycle's pop/push, so a push into a
    // full FIFO is dropped even if the shifter pops in the same cycle.
    assign push = wr_data & ~fifo_full;
    assign pop  = (state == IDLE) & ~fifo_empty;

    assign div_m1   = divisor - 16'd1;
    assign bit_done = (baud_cnt == '0);

    assign status_word = {28'b0, ovf, busy, fifo_empty, fifo_full};

    // FIFO storage write (no reset needed; contents qualified by pointers)
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= i_wb_dat[7:0];
        end
    end

    // FIFO pointer update
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Bus handshake, register reads, divisor and overflow flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wb_ack <= 1'b0;
            o_wb_rdt <= '0;
            divisor  <= DIV_INIT;
            ovf      <= 1'b0;
        end else begin
            o_wb_ack <= bus_acc;
            o_wb_rdt <= '0;
            if (bus_acc && !i_wb_we) begin
                o_wb_rdt <= i_wb_adr ? {16'b0, divisor} : status_word;
            end
            if (wr_div) begin
                divisor <= (i_wb_dat[15:0] == '0) ? 16'd1 : i_wb_dat[15:0];
            end
            if (wr_data && fifo_full) begin
                ovf <= 1'b1;
            end else if (rd_status) begin
                ovf <= 1'b0;
            end
        end
    end

    // Shifter state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Shifter next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!fifo_empty)                   state_nxt = START;
            START:   if (bit_done)                      state_nxt = DATA;
            DATA:    if (bit_done && bit_idx == 3'd7)   state_nxt = STOP;
            STOP:    if (bit_done)                      state_nxt = IDLE;
            default:                                    state_nxt = IDLE;
        endcase
    end

    // Shifter outputs: line level and busy flag
    always_comb begin
        o_tx = 1'b1;
        busy = 1'b1;
        case (state)
            IDLE:    busy = 1'b0;
            START:   o_tx = 1'b0;
            DATA:    o_tx = shift_reg[bit_idx];
            STOP:    o_tx = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    assign o_irq = fifo_empty & ~busy;

    // Baud counter, bit index and shift register. The counter is reloaded
    // from the divisor only at a bit boundary, so a divisor write lands on
    // the next bit and never stretches or shortens the current one.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift_reg <= fifo_mem[rd_ptr[AW-1:0]];
                        baud_cnt  <= div_m1;
                        bit_idx   <= '0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        baud_cnt <= div_m1;
                        bit_idx  <= '0;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        baud_cnt <= div_m1;
                        bit_idx  <= bit_idx + 3'd1;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (!bit_done) begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: begin
                    baud_cnt <= '0;
                end
            endcase
        end
    end

endmodule
